// File: rtl/phy_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_pkg
//  Description : Shared constants and state encoding for the PHY lane
//                receiver. LOSS_COUNT_DEF exists only when RX_LOCK_LOSS_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_rx_pkg;

  localparam int         DATA_W_DEF    = 8;
  localparam logic [7:0] COM_SYM       = 8'hBC;  // idle/alignment symbol sent by phy_tx
  localparam int         COM_COUNT_DEF = 4;
`ifdef RX_LOCK_LOSS_EN
  localparam int         LOSS_COUNT_DEF = 2;
`endif

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNING = 2'd1,
    ACTIVE   = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/phy_rx_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_shift_reg
//  Description : Serial-in shift register with a symbol bit counter. Presents
//                the window that includes the current bit (shift_nx) and a
//                flag marking the last bit of a symbol.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,      // freeze register and counter
  input  logic              align,     // current bit closes a symbol
  input  logic              data_in,
  output logic [DATA_W-1:0] shift_nx,
  output logic              boundary
);

  localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  // Only DATA_W-1 history bits are kept: the oldest bit falls out of the
  // window on the very next shift, so it is never needed.
  logic [DATA_W-2:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;

  assign shift_nx = {r_shift, data_in};
  assign boundary = (r_bit_cnt == LAST);

  // Shift one bit per edge; counter restarts after an alignment hit or a boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (!hold) begin
      r_shift <= shift_nx[DATA_W-2:0];
      if (align || boundary) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/phy_rx_lane_deser.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_lane_deser
//  Description : Receive side of one PHY lane. Aligns to the COM symbol,
//                declares the lane active after COM_COUNT aligned COMs and
//                recovers data bytes with a one-cycle valid strobe.
//                Optional feature macro: RX_LOCK_LOSS_EN (misaligned COMs
//                drop the lane back to UNLOCKED).
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_lane_deser
  import phy_rx_pkg::*;
#(
  parameter int              DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] COM      = DATA_W'(COM_SYM),
`ifdef RX_LOCK_LOSS_EN
  parameter int              LOSS_COUNT = LOSS_COUNT_DEF,
`endif
  parameter int              COM_COUNT  = COM_COUNT_DEF
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              enable,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);

  localparam int              CNT_W  = $clog2(COM_COUNT + 1);
  localparam logic [CNT_W-1:0] C_SAT = CNT_W'(COM_COUNT);

  logic [DATA_W-1:0] w_shift_nx;
  logic              w_boundary;
  logic              w_align;
  logic              w_is_com;

  rx_state_t         r_state, w_state_nx;
  logic [CNT_W-1:0]  r_com_cnt, w_com_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;
  logic              r_valid, w_valid_nx;

`ifdef RX_LOCK_LOSS_EN
  localparam int               MISS_W = $clog2(LOSS_COUNT + 1);
  localparam logic [MISS_W-1:0] C_LOSS = MISS_W'(LOSS_COUNT);
  logic [MISS_W-1:0] r_miss_cnt, w_miss_nx;
`endif

  phy_rx_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk_8f),
    .reset    (reset),
    .hold     (!enable),
    .align    (w_align),
    .data_in  (data_in),
    .shift_nx (w_shift_nx),
    .boundary (w_boundary)
  );

  assign w_is_com  = (w_shift_nx == COM);
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign active    = (r_state == ACTIVE);

  // Next-state and output decode; everything holds and the strobe drops by default.
  always_comb begin
    w_state_nx = r_state;
    w_com_nx   = r_com_cnt;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_align    = 1'b0;
`ifdef RX_LOCK_LOSS_EN
    w_miss_nx  = r_miss_cnt;
`endif
    if (enable) begin
      case (r_state)
        UNLOCKED: begin
          // Bit-by-bit hunt: a COM in the window fixes the symbol boundary here.
          if (w_is_com) begin
            w_state_nx = ALIGNING;
            w_com_nx   = CNT_W'(1);
            w_align    = 1'b1;
          end
        end
        ALIGNING: begin
          if (w_boundary) begin
            if (w_is_com) begin
              if (r_com_cnt + CNT_W'(1) >= C_SAT) begin
                w_state_nx = ACTIVE;
                w_com_nx   = C_SAT;
              end else begin
                w_com_nx = r_com_cnt + CNT_W'(1);
              end
            end else begin
              w_state_nx = UNLOCKED;
              w_com_nx   = '0;
            end
          end
        end
        ACTIVE: begin
          if (w_boundary) begin
            if (!w_is_com) begin
              w_data_nx  = w_shift_nx;
              w_valid_nx = 1'b1;
            end
`ifdef RX_LOCK_LOSS_EN
            else begin
              w_miss_nx = '0;
            end
          end else if (w_is_com) begin
            // COM seen off the boundary: the lane has slipped.
            if (r_miss_cnt + MISS_W'(1) >= C_LOSS) begin
              w_state_nx = UNLOCKED;
              w_com_nx   = '0;
              w_miss_nx  = '0;
            end else begin
              w_miss_nx = r_miss_cnt + MISS_W'(1);
            end
`endif
          end
        end
        default: begin
          w_state_nx = UNLOCKED;
          w_com_nx   = '0;
        end
      endcase
    end
  end

  // State, counters and output registers; reset overrides enable.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      r_state    <= UNLOCKED;
      r_com_cnt  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
`ifdef RX_LOCK_LOSS_EN
      r_miss_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_com_cnt  <= w_com_nx;
      r_data     <= w_data_nx;
      r_valid    <= w_valid_nx;
`ifdef RX_LOCK_LOSS_EN
      r_miss_cnt <= w_miss_nx;
`endif
    end
  end

endmodule
`default_nettype wire
